// File: rtl/weights_fetch_ctrl.sv
// Weight fetch controller: reads LANES weights from a 1-cycle-latency BRAM, packs them and hands the word to the register file.
// Define WEIGHTS_FETCH_STALL_CNT_EN to add a saturating stall_cnt output counting consumer back-pressure cycles.
module weights_fetch_ctrl #(
  parameter int WTS_WIDTH  = 17,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [CNT_WIDTH-1:0]         num_groups,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [WTS_WIDTH-1:0]         mem_rdata,
  output logic [WTS_WIDTH*LANES-1:0]   wts_out,
  output logic                         wts_load,
  input  logic                         wts_ready,
  output logic                         busy,
  output logic                         done
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int LCW = $clog2(LANES + 1);
  localparam int IDW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

  state_t                       state_q, state_d;
  logic [LCW-1:0]               lane_cnt_q, lane_cnt_d;
  logic [CNT_WIDTH-1:0]         grp_cnt_q, grp_cnt_d;
  logic [CNT_WIDTH-1:0]         num_groups_q, num_groups_d;
  logic [ADDR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic                         mem_rd_en_q, mem_rd_en_d;
  logic [IDW-1:0]               issue_idx_q, issue_idx_d;
  logic [IDW-1:0]               cap_idx_q, cap_idx_d;
  logic                         cap_vld_q, cap_vld_d;
  logic [WTS_WIDTH*LANES-1:0]   wts_out_q, wts_out_d;
  logic                         wts_load_q, wts_load_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
  logic [15:0]                  stall_cnt_q, stall_cnt_d;
`endif

  // Read pointer advances once per issued read, so group boundaries and address wrap come for free.
  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    num_groups_d = num_groups_q;
    rd_ptr_d     = rd_ptr_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_en_d  = 1'b0;
    issue_idx_d  = issue_idx_q;
    cap_vld_d    = mem_rd_en_q;
    cap_idx_d    = issue_idx_q;
    wts_out_d    = wts_out_q;
    wts_load_d   = wts_load_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
    stall_cnt_d  = stall_cnt_q;
`endif

    for (int l = 0; l < LANES; l++) begin
      if (cap_vld_q && (cap_idx_q == IDW'(l))) begin
        wts_out_d[l*WTS_WIDTH +: WTS_WIDTH] = mem_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d       = 1'b1;
          num_groups_d = num_groups;
          rd_ptr_d     = base_addr;
          lane_cnt_d   = '0;
          grp_cnt_d    = '0;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
          stall_cnt_d  = '0;
`endif
          if (num_groups != '0) begin
            state_d = FETCH;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      FETCH: begin
        if (lane_cnt_q != LCW'(LANES)) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = rd_ptr_q;
          rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
          issue_idx_d = IDW'(lane_cnt_q);
          lane_cnt_d  = lane_cnt_q + LCW'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d    = PRESENT;
        wts_load_d = 1'b1;
      end
      PRESENT: begin
        if (wts_ready) begin
          wts_load_d = 1'b0;
          if (grp_cnt_q == num_groups_q - CNT_WIDTH'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = FETCH;
            grp_cnt_d  = grp_cnt_q + CNT_WIDTH'(1);
            lane_cnt_d = '0;
          end
        end
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
        else if (stall_cnt_q != 16'hFFFF) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lane_cnt_q   <= '0;
      grp_cnt_q    <= '0;
      num_groups_q <= '0;
      rd_ptr_q     <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      issue_idx_q  <= '0;
      cap_idx_q    <= '0;
      cap_vld_q    <= 1'b0;
      wts_out_q    <= '0;
      wts_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      num_groups_q <= num_groups_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_en_q  <= mem_rd_en_d;
      issue_idx_q  <= issue_idx_d;
      cap_idx_q    <= cap_idx_d;
      cap_vld_q    <= cap_vld_d;
      wts_out_q    <= wts_out_d;
      wts_load_q   <= wts_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign wts_out   = wts_out_q;
  assign wts_load  = wts_load_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_weights_fetch_ctrl.sv
// Self-checking bench for weights_fetch_ctrl: BRAM model, address/word scoreboard and table of fetch sequences.
`timescale 1ns/1ps
module tb_weights_fetch_ctrl;

  localparam int WTS_WIDTH  = 17;
  localparam int LANES      = 4;
  localparam int ADDR_WIDTH = 10;
  localparam int CNT_WIDTH  = 8;
  localparam int WORD_W     = WTS_WIDTH * LANES;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic                   wts_ready = 1'b0;
  logic [ADDR_WIDTH-1:0]  base_addr = '0;
  logic [CNT_WIDTH-1:0]   num_groups = '0;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [WTS_WIDTH-1:0]   mem_rdata = '0;
  logic [WORD_W-1:0]      wts_out;
  logic                   wts_load;
  logic                   busy;
  logic                   done;
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
  logic [15:0]            stall_cnt;
`endif

  typedef struct {
    int    base;
    int    groups;
    int    stall;
    bit    readyEarly;
    bit    poke;
    int    expReads;
    int    expStall;
    string name;
  } vec_t;

  logic [WTS_WIDTH-1:0] bram [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] addrQ[$];
  logic [WORD_W-1:0]     wordQ[$];

  int   nCompared = 0;
  int   nMismatched = 0;
  bit   monActive = 1'b0;
  int   cyc = 0;
  int   trigCycle = 0;
  int   doneCount = 0;
  int   doneCycles = 0;
  int   readCount = 0;
  int   expLoadLen = 1;
  int   loadLen = 0;
  logic prevLoad = 1'b0;
  logic prevBusy = 1'b0;
  logic prevDone = 1'b0;
  logic [WORD_W-1:0] heldWord = '0;
  vec_t vecs[7];

  weights_fetch_ctrl #(
    .WTS_WIDTH (WTS_WIDTH),
    .LANES     (LANES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_groups(num_groups),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .wts_out   (wts_out),
    .wts_load  (wts_load),
    .wts_ready (wts_ready),
    .busy      (busy),
    .done      (done)
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Single-port BRAM with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= bram[mem_addr];
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: pops expected addresses on each read and expected words on each new wts_load.
  always @(negedge clock) begin
    if (monActive) begin
      if (mem_rd_en) begin
        readCount++;
        if (addrQ.size() == 0) checkOutput("extra_read", mem_rd_en, 1'b0);
        else checkOutput("rd_addr", mem_addr, addrQ.pop_front());
      end
      if (busy && !prevBusy) trigCycle = cyc;
      if (prevLoad && !wts_load) begin
        trigCycle = cyc;
        checkOutput("load_len", loadLen, expLoadLen);
      end
      if (wts_load && !prevLoad) begin
        checkOutput("load_latency", cyc - trigCycle, LANES + 2);
        if (wordQ.size() == 0) checkOutput("extra_load", wts_load, 1'b0);
        else checkOutput("wts_word", wts_out, wordQ.pop_front());
        heldWord = wts_out;
        loadLen = 1;
      end else if (wts_load) begin
        checkOutput("wts_hold", wts_out, heldWord);
        loadLen++;
      end
      if (done) begin
        doneCycles++;
        if (!prevDone) begin
          doneCount++;
          checkOutput("done_latency", cyc - trigCycle, 0);
        end
      end
    end
    prevLoad = wts_load;
    prevBusy = busy;
    prevDone = done;
  end

  task automatic pushExpect(input int base, input int groups);
    logic [WORD_W-1:0] w;
    int a;
    for (int g = 0; g < groups; g++) begin
      w = '0;
      for (int l = 0; l < LANES; l++) begin
        a = (base + g * LANES + l) % DEPTH;
        addrQ.push_back(ADDR_WIDTH'(a));
        w[l*WTS_WIDTH +: WTS_WIDTH] = bram[a];
      end
      wordQ.push_back(w);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    $display("[TB] sequence %s base=%0d groups=%0d", v.name, v.base, v.groups);
    pushExpect(v.base, v.groups);
    doneCount = 0;
    doneCycles = 0;
    readCount = 0;
    expLoadLen = v.readyEarly ? 1 : v.stall + 1;
    wts_ready = v.readyEarly;
    base_addr = ADDR_WIDTH'(v.base);
    num_groups = CNT_WIDTH'(v.groups);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    base_addr = '0;
    num_groups = '0;
    if (v.poke) begin
      @(negedge clock);
      start = 1'b1;
      base_addr = ADDR_WIDTH'(100);
      num_groups = CNT_WIDTH'(7);
      @(negedge clock);
      start = 1'b0;
    end
    if (!v.readyEarly) begin
      for (int g = 0; g < v.groups; g++) begin
        n = 0;
        while (!wts_load && n < 40) begin
          @(negedge clock);
          n++;
        end
        if (!wts_load) begin
          checkOutput("load_timeout", wts_load, 1'b1);
          break;
        end
        repeat (v.stall) @(negedge clock);
        wts_ready = 1'b1;
        @(negedge clock);
        wts_ready = 1'b0;
      end
    end
    n = 0;
    while (busy && n < v.groups * 12 + 20) begin
      @(negedge clock);
      n++;
    end
    wts_ready = 1'b0;
    checkOutput("busy_end", busy, 1'b0);
    checkOutput("done_count", doneCount, 1);
    checkOutput("done_width", doneCycles, 1);
    checkOutput("read_count", readCount, v.expReads);
    checkOutput("addr_left", addrQ.size(), 0);
    checkOutput("word_left", wordQ.size(), 0);
`ifdef WEIGHTS_FETCH_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, v.expStall);
`endif
    addrQ.delete();
    wordQ.delete();
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) bram[i] = WTS_WIDTH'(i + 1);
    vecs[0] = '{0,    1,   0, 1'b0, 1'b0, 4,    0,  "single"};
    vecs[1] = '{8,    3,   5, 1'b0, 1'b0, 12,   15, "multi_stall"};
    vecs[2] = '{0,    0,   0, 1'b0, 1'b0, 0,    0,  "zero_groups"};
    vecs[3] = '{1022, 1,   0, 1'b0, 1'b0, 4,    0,  "addr_wrap"};
    vecs[4] = '{500,  2,   0, 1'b1, 1'b0, 8,    0,  "ready_early"};
    vecs[5] = '{40,   1,   2, 1'b0, 1'b1, 4,    2,  "start_busy"};
    vecs[6] = '{900,  255, 0, 1'b1, 1'b0, 1020, 0,  "max_groups"};

    repeat (3) @(negedge clock);
    checkOutput("rst_rd_en", mem_rd_en, 1'b0);
    checkOutput("rst_addr", mem_addr, '0);
    checkOutput("rst_wts_out", wts_out, '0);
    checkOutput("rst_load", wts_load, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    reset = 1'b1;
    monActive = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Abandon a sequence with reset while the packed word is presented.
    $display("[TB] sequence reset_mid_present");
    pushExpect(0, 1);
    base_addr = '0;
    num_groups = CNT_WIDTH'(1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!wts_load && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput("rm_load_seen", wts_load, 1'b1);
    #2;
    monActive = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("rm_rd_en", mem_rd_en, 1'b0);
    checkOutput("rm_addr", mem_addr, '0);
    checkOutput("rm_wts_out", wts_out, '0);
    checkOutput("rm_load", wts_load, 1'b0);
    checkOutput("rm_busy", busy, 1'b0);
    checkOutput("rm_done", done, 1'b0);
    addrQ.delete();
    wordQ.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    doneCount = 0;
    monActive = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("rm_stale_done", doneCount, 0);
    checkOutput("rm_idle_busy", busy, 1'b0);
    applyStimulus(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
